apb_multi_slave_responder: RTL and testbench

- Parametrised APB completer model serving NUM_SLV independent register-file slaves behind one shared APB bus.
- Successor to the fixed single-responder APB driver path. Adds configurable data/address width, slave count, per-slave depth, wait-state insertion, PREADY/PSLVERR, and a protocol-violation counter.
- Sits on the APB side of the AHB-to-APB bridge as the synthesizable slave population for bridge regressions.

---
 rtl/apb_resp_pkg.sv | 37 +++
 rtl/apb_multi_slave_responder_mem.sv | 44 ++++
 rtl/apb_multi_slave_responder.sv | 175 +++++++++++++++++
 tb/tb_apb_multi_slave_responder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_resp_pkg.sv
// Shared types and sizing helpers for the APB multi-slave responder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package apb_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        MULTI_SEL = 2'd1,
        MISALIGN  = 2'd2,
        RANGE     = 2'd3
    } err_cause_t;

    // proto_err_cnt stops here instead of wrapping
    localparam logic [7:0] PROTO_CNT_MAX = 8'hFF;

    // byte-offset bits inside one data word
    function automatic int align_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // word-index bits inside one slave
    function automatic int idx_bits(input int depth);
        return $clog2(depth);
    endfunction

    // encoded slave-number width, never zero
    function automatic int sel_bits(input int num_slv);
        return (num_slv < 2) ? 1 : $clog2(num_slv);
    endfunction

endpackage

// File: rtl/apb_multi_slave_responder_mem.sv
// NUM_SLV x DEPTH x DATA_W register storage with byte-enable write, async clear.
// Latency: write commits on the clock edge; read port is combinational.
// Backpressure: none, a write is always accepted.
module apb_resp_mem #(
    parameter int NUM_SLV = 4,
    parameter int DEPTH   = 16,
    parameter int DATA_W  = 32,
    parameter int SLV_W   = 2,
    parameter int IDX_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [SLV_W-1:0]    wr_slv,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [DATA_W-1:0]   wr_dat,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [SLV_W-1:0]    rd_slv,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [DATA_W-1:0]   rd_dat
);

    logic [DATA_W-1:0] mem [NUM_SLV][DEPTH];

    // clear every word on reset, otherwise merge strobed bytes into one word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SLV; s++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[s][i] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wr_be[b]) begin
                    mem[wr_slv][wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
                end
            end
        end
    end

    assign rd_dat = mem[rd_slv][rd_idx];

endmodule

// File: rtl/apb_multi_slave_responder.sv
// APB completer serving NUM_SLV register-file slaves; optional APB_PSTRB_EN adds pstrb.
// Latency: SETUP + (WAIT_CYCLES + 1) ACCESS cycles; pready is combinational in the last one.
// Backpressure: pready held low for WAIT_CYCLES ACCESS cycles; aborted transfers drop.
module apb_multi_slave_responder
    import apb_resp_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SLV-1:0]  psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb,
`endif
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr,
    output logic [7:0]          proto_err_cnt
);

    localparam int ALIGN  = align_bits(DATA_W);
    localparam int IDX_W  = idx_bits(DEPTH);
    localparam int SLV_W  = sel_bits(NUM_SLV);
    localparam int STRB_W = DATA_W / 8;
    localparam int TOP_B  = IDX_W + ALIGN;

    state_t             state;
    logic [NUM_SLV-1:0] lat_sel;
    logic [SLV_W-1:0]   lat_slv;
    logic [IDX_W-1:0]   lat_idx;
    logic               lat_write;
    logic [DATA_W-1:0]  lat_wdata;
    logic [STRB_W-1:0]  lat_strb;
    err_cause_t         lat_cause;
    logic               lat_strb_err;
    logic [3:0]         wcnt;

    logic [SLV_W-1:0]   sel_enc;
    err_cause_t         cause_in;
    logic [STRB_W-1:0]  strb_in;
    logic               strb_err_in;
    logic [ADDR_W-1:0]  align_mask;
    logic               hold;
    logic               lat_err;
    logic               wr_en;
    logic [7:0]         cnt_inc;
    logic [DATA_W-1:0]  rd_dat;

`ifdef APB_PSTRB_EN
    assign strb_in     = pstrb;
    assign strb_err_in = !pwrite && (|pstrb);
`else
    assign strb_in     = '1;
    assign strb_err_in = 1'b0;
`endif

    assign align_mask = (ADDR_W'(1) << ALIGN) - ADDR_W'(1);

    // lowest set psel bit picks the slave; multi-select is flagged as an error anyway
    always_comb begin
        sel_enc = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (psel[i]) sel_enc = SLV_W'(i);
        end
    end

    // address/select decode at setup latch, first matching cause wins
    always_comb begin
        cause_in = NONE;
        if ((psel & (psel - NUM_SLV'(1))) != '0) begin
            cause_in = MULTI_SEL;
        end else if ((paddr & align_mask) != '0) begin
            cause_in = MISALIGN;
        end else if ((paddr >> TOP_B) != '0) begin
            cause_in = RANGE;
        end
    end

    assign hold    = (psel == lat_sel) && penable;
    assign lat_err = (lat_cause != NONE) || lat_strb_err;
    assign pready  = (state == ACCESS) && (wcnt == 4'd0);
    assign pslverr = pready && lat_err;
    assign wr_en   = pready && hold && lat_write && !lat_err;
    assign cnt_inc = (proto_err_cnt == PROTO_CNT_MAX) ? proto_err_cnt : proto_err_cnt + 8'd1;

    apb_resp_mem #(
        .NUM_SLV (NUM_SLV),
        .DEPTH   (DEPTH),
        .DATA_W  (DATA_W),
        .SLV_W   (SLV_W),
        .IDX_W   (IDX_W)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_slv (lat_slv),
        .wr_idx (lat_idx),
        .wr_dat (lat_wdata),
        .wr_be  (lat_strb),
        .rd_slv (lat_slv),
        .rd_idx (lat_idx),
        .rd_dat (rd_dat)
    );

    // transfer sequencing, request latching, read-data register and violation counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            prdata        <= '0;
            proto_err_cnt <= '0;
            wcnt          <= '0;
            lat_sel       <= '0;
            lat_slv       <= '0;
            lat_idx       <= '0;
            lat_write     <= 1'b0;
            lat_wdata     <= '0;
            lat_strb      <= '0;
            lat_cause     <= NONE;
            lat_strb_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    prdata <= '0;
                    if (|psel) begin
                        if (!penable) begin
                            lat_sel      <= psel;
                            lat_slv      <= sel_enc;
                            lat_idx      <= paddr[TOP_B-1:ALIGN];
                            lat_write    <= pwrite;
                            lat_wdata    <= pwdata;
                            lat_strb     <= strb_in;
                            lat_cause    <= cause_in;
                            lat_strb_err <= strb_err_in;
                            wcnt         <= 4'(WAIT_CYCLES);
                            state        <= SETUP;
                        end else begin
                            proto_err_cnt <= cnt_inc;
                        end
                    end
                end
                SETUP: begin
                    if (hold) begin
                        prdata <= (lat_write || lat_err) ? '0 : rd_dat;
                        state  <= ACCESS;
                    end else begin
                        proto_err_cnt <= cnt_inc;
                        state         <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!hold) begin
                        proto_err_cnt <= cnt_inc;
                        prdata        <= '0;
                        state         <= IDLE;
                    end else if (wcnt == 4'd0) begin
                        prdata <= '0;
                        state  <= IDLE;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_multi_slave_responder.sv
// Self-checking bench: three responders (0, 3 and 2 wait states) on gated psel lines.
// Latency: checks pready timing per instance against its wait-state count.
// Backpressure: master holds penable until pready, drops it deliberately in abort tests.
module tb_apb_multi_slave_responder;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DP = 16;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          rd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    int            dsel;

    logic [NS-1:0] psel0, psel1, psel2;
    logic [DW-1:0] prd0, prd1, prd2;
    logic          rdy0, rdy1, rdy2;
    logic          err0, err1, err2;
    logic [7:0]    cnt0, cnt1, cnt2;

    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic [7:0]    pcnt;

    logic [DW-1:0] mdl [3][NS][DP];
    exp_t          sbq [$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    assign psel0 = (dsel == 0) ? psel : '0;
    assign psel1 = (dsel == 1) ? psel : '0;
    assign psel2 = (dsel == 2) ? psel : '0;

    always_comb begin
        prdata = prd0; pready = rdy0; pslverr = err0; pcnt = cnt0;
        if (dsel == 1) begin
            prdata = prd1; pready = rdy1; pslverr = err1; pcnt = cnt1;
        end else if (dsel == 2) begin
            prdata = prd2; pready = rdy2; pslverr = err2; pcnt = cnt2;
        end
    end

    apb_multi_slave_responder #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .DEPTH(DP), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prd0), .pready(rdy0), .pslverr(err0), .proto_err_cnt(cnt0));

    apb_multi_slave_responder #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .DEPTH(DP), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst), .psel(psel1), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prd1), .pready(rdy1), .pslverr(err1), .proto_err_cnt(cnt1));

    apb_multi_slave_responder #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .DEPTH(DP), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .psel(psel2), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prd2), .pready(rdy2), .pslverr(err2), .proto_err_cnt(cnt2));

    function automatic int wait_of(input int d);
        return (d == 1) ? 3 : ((d == 2) ? 2 : 0);
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int s = 0; s < NS; s++)
                for (int i = 0; i < DP; i++)
                    mdl[d][s][i] = '0;
    endtask

    // one complete transfer; expectation comes from the reference model
    task automatic apb_xfer(input int d, input logic [NS-1:0] sel, input logic w,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [3:0] strb);
        exp_t          e;
        exp_t          got;
        logic          err;
        int            slv;
        int            idx;
        int            n;
        logic [3:0]    be;
        err = ((sel & (sel - 4'd1)) != 4'd0) || (addr[1:0] != 2'd0) || ((addr >> 6) != 0);
`ifdef APB_PSTRB_EN
        be = strb;
        if (!w && strb != 4'd0) err = 1'b1;
`else
        be = 4'hF;
`endif
        slv = 0;
        for (int i = NS - 1; i >= 0; i--) if (sel[i]) slv = i;
        idx = int'(addr[5:2]);
        e.rd    = !w;
        e.err   = err;
        e.rdata = (err || w) ? '0 : mdl[d][slv][idx];
        if (w && !err)
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[d][slv][idx][b*8 +: 8] = wdata[b*8 +: 8];
        sbq.push_back(e);

        dsel = d; psel = sel; penable = 1'b0; pwrite = w;
        paddr = addr; pwdata = wdata; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        checks++;
        if (pready !== 1'b0) begin
            errors++;
            $display("FAIL setup_pready: got %b expected 0 (dut %0d addr %h)", pready, d, addr);
        end
        @(posedge clk); #1;
        n = 0;
        while (!pready && n < 40) begin
            if (e.rd) begin
                checks++;
                if (prdata !== e.rdata) begin
                    errors++;
                    $display("FAIL prdata_hold: got %h expected %h (dut %0d)", prdata, e.rdata, d);
                end
            end
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != wait_of(d)) begin
            errors++;
            $display("FAIL wait_states: got %0d expected %0d (dut %0d)", n, wait_of(d), d);
        end
        got = sbq.pop_front();
        checks++;
        if (pslverr !== got.err) begin
            errors++;
            $display("FAIL pslverr: got %b expected %b (dut %0d addr %h sel %b)", pslverr, got.err, d, addr, sel);
        end
        if (got.rd) begin
            checks++;
            if (prdata !== got.rdata) begin
                errors++;
                $display("FAIL prdata: got %h expected %h (dut %0d addr %h sel %b)", prdata, got.rdata, d, addr, sel);
            end
        end
        @(posedge clk); #1;
        psel = '0; penable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; dsel = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            dsel = d; #1;
            checks++;
            if (prdata !== '0 || pready !== 1'b0 || pslverr !== 1'b0 || pcnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_state: dut %0d got prdata %h pready %b pslverr %b cnt %0d expected all 0",
                         d, prdata, pready, pslverr, pcnt);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        apb_xfer(0, 4'b0100, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
        apb_xfer(0, 4'b0100, 1'b0, 32'h8, 32'h0, 4'h0);
        checks++;
        if (mdl[0][2][2] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL model_word: got %h expected deadbeef", mdl[0][2][2]);
        end
    endtask

    task automatic test_wait();
        apb_xfer(1, 4'b0001, 1'b0, 32'h0, 32'h0, 4'h0);
        apb_xfer(1, 4'b1000, 1'b1, 32'h3C, 32'h0BADF00D, 4'hF);
        apb_xfer(1, 4'b1000, 1'b0, 32'h3C, 32'h0, 4'h0);
    endtask

    task automatic test_multi_sel();
        apb_xfer(0, 4'b0110, 1'b1, 32'h4, 32'h1234, 4'hF);
        apb_xfer(0, 4'b0010, 1'b0, 32'h4, 32'h0, 4'h0);
        apb_xfer(0, 4'b0100, 1'b0, 32'h4, 32'h0, 4'h0);
    endtask

    task automatic test_addr_err();
        apb_xfer(0, 4'b0001, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF);
        apb_xfer(0, 4'b0001, 1'b1, 32'h42, 32'h11111111, 4'hF);
        apb_xfer(0, 4'b0001, 1'b1, 32'h40, 32'h22222222, 4'hF);
        apb_xfer(0, 4'b0001, 1'b0, 32'h40, 32'h0, 4'h0);
        apb_xfer(0, 4'b0001, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_back_to_back();
        apb_xfer(0, 4'b0010, 1'b1, 32'h1C, 32'hCAFEF00D, 4'hF);
        apb_xfer(0, 4'b0010, 1'b0, 32'h1C, 32'h0, 4'h0);
        apb_xfer(0, 4'b0010, 1'b1, 32'h1C, 32'h76543210, 4'hF);
        apb_xfer(0, 4'b0010, 1'b0, 32'h1C, 32'h0, 4'h0);
        apb_xfer(2, 4'b0100, 1'b1, 32'h20, 32'h13579BDF, 4'hF);
        apb_xfer(2, 4'b0100, 1'b0, 32'h20, 32'h0, 4'h0);
    endtask

    task automatic test_proto();
        apb_xfer(2, 4'b0001, 1'b1, 32'h10, 32'h11110000, 4'hF);
        // write aborted by dropping penable during the wait states
        dsel = 2; psel = 4'b0001; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h10; pwdata = 32'h22222222; pstrb = 4'hF;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1; penable = 1'b0;
        @(posedge clk); #1; psel = '0;
        @(posedge clk); #1;
        // setup never followed by an enable cycle
        psel = 4'b0001; penable = 1'b0; pwrite = 1'b1; pwdata = 32'h33333333;
        @(posedge clk); #1;
        @(posedge clk); #1; psel = '0;
        @(posedge clk); #1;
        checks++;
        if (pcnt !== 8'd2) begin
            errors++;
            $display("FAIL proto_cnt_two: got %0d expected 2", pcnt);
        end
        apb_xfer(2, 4'b0001, 1'b0, 32'h10, 32'h0, 4'h0);
        psel = 4'b0001; penable = 1'b1;
        repeat (300) @(posedge clk);
        #1; psel = '0; penable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pcnt !== 8'd255) begin
            errors++;
            $display("FAIL proto_cnt_sat: got %0d expected 255", pcnt);
        end
        apb_xfer(2, 4'b0001, 1'b0, 32'h10, 32'h0, 4'h0);
    endtask

`ifdef APB_PSTRB_EN
    task automatic test_pstrb();
        apb_xfer(0, 4'b1000, 1'b1, 32'h0, 32'hFFFFFFFF, 4'b0101);
        checks++;
        if (mdl[0][3][0] !== 32'h00FF00FF) begin
            errors++;
            $display("FAIL strb_model: got %h expected 00ff00ff", mdl[0][3][0]);
        end
        apb_xfer(0, 4'b1000, 1'b0, 32'h0, 32'h0, 4'h0);
        apb_xfer(0, 4'b1000, 1'b0, 32'h0, 32'h0, 4'b0001);
    endtask
`endif

    task automatic test_reset_mid();
        apb_xfer(1, 4'b0001, 1'b1, 32'h8, 32'h55555555, 4'hF);
        dsel = 1; psel = 4'b0001; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h8; pstrb = 4'h0;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (prdata !== 32'h55555555 || pready !== 1'b0) begin
            errors++;
            $display("FAIL mid_access: got prdata %h pready %b expected 55555555 0", prdata, pready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (prdata !== '0 || pready !== 1'b0 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got prdata %h pready %b pslverr %b expected 0", prdata, pready, pslverr);
        end
        dsel = 2; #1;
        checks++;
        if (pcnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", pcnt);
        end
        @(posedge clk); #1;
        rst = 1'b0; psel = '0; penable = 1'b0;
        clear_model();
        @(posedge clk); #1;
        apb_xfer(1, 4'b0001, 1'b0, 32'h8, 32'h0, 4'h0);
        apb_xfer(0, 4'b0100, 1'b0, 32'h8, 32'h0, 4'h0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_multi_sel();
        test_addr_err();
        test_back_to_back();
        test_proto();
`ifdef APB_PSTRB_EN
        test_pstrb();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
